// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Optional feature macro: MDU_FAST_MULT_EN (single-cycle MULT/MULTU).
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = MDU_WIDTH;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    // True for the ops that occupy the arithmetic datapath.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative unsigned restoring divider core: one quotient bit per step.
// quotient_o/remainder_o are the values the registers take at the next step,
// so the owner can capture the final result on the same edge as the last step.
// Optional feature macro of the enclosing unit: MDU_FAST_MULT_EN (no effect here).
module mdu_divider #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic [Width-1:0] quotient_o,
    output logic [Width-1:0] remainder_o
);

    logic [Width-1:0] r_quo;
    logic [Width-1:0] r_rem;
    logic [Width-1:0] r_dvs;

    logic [Width:0]   w_shift;
    logic [Width:0]   w_diff;
    logic             w_fits;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_shift     = {r_rem, r_quo[Width-1]};
    assign w_diff      = w_shift - {1'b0, r_dvs};
    assign w_fits      = ~w_diff[Width];
    assign remainder_o = w_fits ? w_diff[Width-1:0] : w_shift[Width-1:0];
    assign quotient_o  = {r_quo[Width-2:0], w_fits};

    // Load operands on start, otherwise advance one bit per step.
    // NOTE: pure datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (start_i) begin
            r_quo <= dividend_i;
            r_rem <= '0;
            r_dvs <= divisor_i;
        end else if (step_i) begin
            r_quo <= quotient_o;
            r_rem <= remainder_o;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional feature macro: MDU_FAST_MULT_EN -- MULT/MULTU finish at the
// acceptance edge with a single-cycle multiplier; DIV/DIVU stay iterative.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int Width = MDU_ITER
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             flush_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CntW = $clog2(Width);

    mdu_state_t         r_state;
    logic [CntW-1:0]    r_count;
    logic [Width-1:0]   r_hi;
    logic [Width-1:0]   r_lo;
    logic               r_done;

    // Operation context captured at acceptance.
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [Width-1:0]   r_a;
    logic [Width-1:0]   r_mcand;
    logic [2*Width-1:0] r_prod;

    logic               w_accept;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [Width-1:0]   w_a_mag;
    logic [Width-1:0]   w_b_mag;
    logic [Width:0]     w_sum;
    logic [2*Width-1:0] w_prod_next;
    logic [2*Width-1:0] w_mul_res;
    logic [Width-1:0]   w_quo_next;
    logic [Width-1:0]   w_rem_next;
    logic [Width-1:0]   w_div_hi;
    logic [Width-1:0]   w_div_lo;

    assign w_accept = start_i && (r_state == IDLE) && !flush_i && is_arith_op(op_i);
    assign w_is_div = is_div_op(op_i);
    assign w_a_neg  = is_signed_op(op_i) && a_i[Width-1];
    assign w_b_neg  = is_signed_op(op_i) && b_i[Width-1];
    assign w_a_mag  = w_a_neg ? -a_i : a_i;
    assign w_b_mag  = w_b_neg ? -b_i : b_i;

    // Shift-add multiplier step: add multiplicand under the low product bit, shift right.
    assign w_sum       = {1'b0, r_prod[2*Width-1:Width]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_sum, r_prod[Width-1:1]};
    assign w_mul_res   = r_neg_q ? -w_prod_next : w_prod_next;

    mdu_divider #(.Width(Width)) u_divider (
        .clk_i       (clk_i),
        .start_i     (w_accept && w_is_div),
        .step_i      ((r_state == RUN) && r_is_div),
        .dividend_i  (w_a_mag),
        .divisor_i   (w_b_mag),
        .quotient_o  (w_quo_next),
        .remainder_o (w_rem_next)
    );

    // Sign fix-up; divide by zero bypasses it and returns all-ones / dividend.
    assign w_div_lo = r_div_zero ? '1  : (r_neg_q ? -w_quo_next : w_quo_next);
    assign w_div_hi = r_div_zero ? r_a : (r_neg_r ? -w_rem_next : w_rem_next);

`ifdef MDU_FAST_MULT_EN
    logic [2*Width-1:0] w_fast_mag;
    logic [2*Width-1:0] w_fast_res;

    assign w_fast_mag = {{Width{1'b0}}, w_a_mag} * {{Width{1'b0}}, w_b_mag};
    assign w_fast_res = (w_a_neg ^ w_b_neg) ? -w_fast_mag : w_fast_mag;
`endif

    // Control FSM plus architectural HI/LO and the done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (flush_i) begin
                r_state <= IDLE;
            end else if (r_state == IDLE) begin
                if (w_accept) begin
`ifdef MDU_FAST_MULT_EN
                    if (!w_is_div) begin
                        r_hi   <= w_fast_res[2*Width-1:Width];
                        r_lo   <= w_fast_res[Width-1:0];
                        r_done <= 1'b1;
                    end else begin
                        r_state <= RUN;
                        r_count <= CntW'(Width - 1);
                    end
`else
                    r_state <= RUN;
                    r_count <= CntW'(Width - 1);
`endif
                end else if (start_i && (op_i == MTHI)) begin
                    r_hi <= a_i;
                end else if (start_i && (op_i == MTLO)) begin
                    r_lo <= a_i;
                end
            end else begin
                if (r_count == '0) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                    if (r_is_div) begin
                        r_hi <= w_div_hi;
                        r_lo <= w_div_lo;
                    end else begin
                        r_hi <= w_mul_res[2*Width-1:Width];
                        r_lo <= w_mul_res[Width-1:0];
                    end
                end else begin
                    r_count <= r_count - CntW'(1);
                end
            end
        end
    end

    // Capture operand context at acceptance and advance the multiplier while running.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_is_div   <= w_is_div;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= (b_i == '0);
            r_a        <= a_i;
            r_mcand    <= w_a_mag;
            r_prod     <= {{Width{1'b0}}, w_b_mag};
        end else if ((r_state == RUN) && !r_is_div) begin
            r_prod <= w_prod_next;
        end
    end

    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
    assign busy_o = (r_state == RUN);
    assign done_o = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Honours MDU_FAST_MULT_EN for the expected multiply latency.
module tb_mult_div_unit;
    import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic        flush_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        done_o;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.Width(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .flush_i (flush_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive start for one cycle (C0); returns in C1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        tick();
        start_i = 1'b0;
    endtask

    // From cycle index c0, wait (bounded) for done_o; returns its cycle index or -1.
    task automatic wait_done(input int c0, output int done_cyc);
        int c;
        c = c0;
        while (!done_o && c < c0 + 60) begin
            tick();
            c++;
        end
        done_cyc = done_o ? c : -1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int dc;
        issue(op, a, b);
        check({tag, "_busy_c1"}, 32'(busy_o), 32'(lat != 1));
        wait_done(1, dc);
        check({tag, "_done_cycle"}, 32'(dc), 32'(lat));
        check({tag, "_hi"}, hi_o, exp_hi);
        check({tag, "_lo"}, lo_o, exp_lo);
        tick();
        check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    endtask

    // Count cycles in which the unit shows any activity.
    task automatic idle_window(input int n, output int active);
        active = 0;
        for (int i = 0; i < n; i++) begin
            if (busy_o || done_o) active++;
            tick();
        end
    endtask

    initial begin
        int n_busy;
        int act;
        int dc;

        rst_i   = 1'b1;
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 3'd0;
        a_i     = '0;
        b_i     = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check("reset_hi",   hi_o, 32'h0);
        check("reset_lo",   lo_o, 32'h0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);

        // MTHI / MTLO write directly without busy or done.
        issue(MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_hi",   hi_o, 32'hDEADBEEF);
        check("mthi_busy", 32'(busy_o), 32'd0);
        check("mthi_done", 32'(done_o), 32'd0);
        issue(MTLO, 32'h12345678, 32'h0);
        check("mtlo_lo",   lo_o, 32'h12345678);
        check("mtlo_hi",   hi_o, 32'hDEADBEEF);
        check("mtlo_done", 32'(done_o), 32'd0);

        // Reset held two cycles in the middle of a DIV.
        issue(DIV, 32'd100, 32'd7);
        repeat (4) tick();
        check("middiv_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check("middiv_rst_hi",   hi_o, 32'h0);
        check("middiv_rst_lo",   lo_o, 32'h0);
        check("middiv_rst_busy", 32'(busy_o), 32'd0);
        check("middiv_rst_done", 32'(done_o), 32'd0);
        idle_window(40, act);
        check("middiv_rst_quiet", 32'(act), 32'd0);

        // DIV -7 / 2 with exact busy window C1..C32 and done in C33.
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        n_busy = 0;
        for (int c = 1; c <= 32; c++) begin
            if (busy_o && !done_o) n_busy++;
            tick();
        end
        check("div7_busy_cycles", 32'(n_busy), 32'd32);
        check("div7_c33_busy", 32'(busy_o), 32'd0);
        check("div7_c33_done", 32'(done_o), 32'd1);
        check("div7_lo", lo_o, 32'hFFFFFFFD);
        check("div7_hi", hi_o, 32'hFFFFFFFF);
        tick();
        check("div7_c34_done", 32'(done_o), 32'd0);

        // Multiplies.
        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m1",   MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'h00000000, 32'h00000001);
        run_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd5,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("mult_min",  MULT,  32'h80000000, 32'h80000000, MUL_LAT, 32'h40000000, 32'h00000000);
        run_op("multu_mix", MULTU, 32'h12345678, 32'h00000010, MUL_LAT, 32'h00000001, 32'h23456780);

        // Divides including boundary cases.
        run_op("divu_zero", DIVU, 32'h00001234, 32'h0,        DIV_LAT, 32'h00001234, 32'hFFFFFFFF);
        run_op("div_ovf",   DIV,  32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000);
        run_op("divu_100",  DIVU, 32'd100,      32'd7,        DIV_LAT, 32'd2,        32'd14);
        run_op("div_m100",  DIV,  32'hFFFFFF9C, 32'd7,        DIV_LAT, 32'hFFFFFFFE, 32'hFFFFFFF2);
        run_op("div_zero",  DIV,  32'hFFFFFF9C, 32'h0,        DIV_LAT, 32'hFFFFFF9C, 32'hFFFFFFFF);

        // start_i during RUN (C5) is ignored.
        issue(DIV, 32'd1000, 32'd3);
        repeat (4) tick();
        start_i = 1'b1;
        op_i    = DIV;
        a_i     = 32'd9;
        b_i     = 32'd3;
        tick();
        start_i = 1'b0;
        wait_done(6, dc);
        check("ignstart_done_cycle", 32'(dc), 32'd33);
        check("ignstart_lo", lo_o, 32'd333);
        check("ignstart_hi", hi_o, 32'd1);
        tick();

        // Flush in C10 of a DIV: busy drops in C11, no done, HI/LO kept.
        issue(DIV, 32'd50, 32'd5);
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_busy_c11", 32'(busy_o), 32'd0);
        idle_window(40, act);
        check("flush_quiet", 32'(act), 32'd0);
        check("flush_lo", lo_o, 32'd333);
        check("flush_hi", hi_o, 32'd1);

        // Flush and start in the same idle cycle: nothing accepted.
        flush_i = 1'b1;
        issue(DIV, 32'd50, 32'd5);
        flush_i = 1'b0;
        check("flushstart_busy", 32'(busy_o), 32'd0);
        idle_window(40, act);
        check("flushstart_quiet", 32'(act), 32'd0);
        flush_i = 1'b1;
        issue(MTHI, 32'h55555555, 32'h0);
        flush_i = 1'b0;
        check("flushmthi_hi", hi_o, 32'd1);

        // MTLO with reset in the same cycle: reset wins.
        rst_i = 1'b1;
        issue(MTLO, 32'hAAAAAAAA, 32'h0);
        rst_i = 1'b0;
        check("mtlo_rst_lo", lo_o, 32'h0);
        check("mtlo_rst_hi", hi_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
